// File: rtl/fc_argmax_classifier.sv
// fc_argmax_classifier: streaming signed argmax over NUM_CLASSES scores per frame.
// Define FC_ARGMAX_MARGIN_EN to add runner-up index and winner margin outputs.
module fc_argmax_classifier #(
    parameter int NUM_CLASSES  = 10,
    parameter int DATA_WIDTH   = 18,
    parameter int IDX_WIDTH    = 4,
    parameter int LEAD_DISCARD = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [IDX_WIDTH-1:0]  decision,
    output logic [DATA_WIDTH-1:0] max_score,
`ifdef FC_ARGMAX_MARGIN_EN
    output logic [IDX_WIDTH-1:0]  second_idx,
    output logic [DATA_WIDTH:0]   margin,
`endif
    output logic                  valid_out,
    output logic                  busy
);
    localparam int DCW = (LEAD_DISCARD > 0) ? $clog2(LEAD_DISCARD + 1) : 1;
    localparam logic [DCW-1:0] DISC_INIT = DCW'(LEAD_DISCARD);
    localparam logic [IDX_WIDTH-1:0] LAST = IDX_WIDTH'(NUM_CLASSES - 1);
    localparam logic S_DISCARD = 1'b0;
    localparam logic S_SCAN = 1'b1;
    localparam logic S_RESET = (LEAD_DISCARD > 0) ? S_DISCARD : S_SCAN;

    logic                  r_state;
    logic                  w_next_state;
    logic [DCW-1:0]        r_disc;
    logic [IDX_WIDTH-1:0]  r_cnt;
    logic [DATA_WIDTH-1:0] r_max;
    logic [IDX_WIDTH-1:0]  r_idx;
    logic                  r_valid;
    logic [IDX_WIDTH-1:0]  r_dec;
    logic [DATA_WIDTH-1:0] r_score;
    logic                  w_take;
    logic                  w_first;
    logic                  w_last;
    logic                  w_gt;
    logic [DATA_WIDTH-1:0] w_max;
    logic [IDX_WIDTH-1:0]  w_idx;

    // Winner including the incoming score, so the frame's last class resolves without an extra cycle.
    assign w_take  = valid_in && (r_state == S_SCAN);
    assign w_first = (r_cnt == '0);
    assign w_last  = w_take && (r_cnt == LAST);
    assign w_gt    = $signed(data_in) > $signed(r_max);
    assign w_max   = (w_first || w_gt) ? data_in : r_max;
    assign w_idx   = (w_first || w_gt) ? r_cnt : r_idx;

`ifdef FC_ARGMAX_MARGIN_EN
    logic [DATA_WIDTH-1:0] r_sec;
    logic [IDX_WIDTH-1:0]  r_sidx;
    logic [IDX_WIDTH-1:0]  r_sidx_out;
    logic [DATA_WIDTH:0]   r_margin;
    logic                  w_sec_take;
    logic [DATA_WIDTH-1:0] w_sec;
    logic [IDX_WIDTH-1:0]  w_sidx;
    logic [DATA_WIDTH:0]   w_margin;

    // Class 1 always seeds the runner-up so a tie with class 0 still gives margin 0.
    assign w_sec_take = ($signed(data_in) > $signed(r_sec)) || (r_cnt == IDX_WIDTH'(1));
    assign w_sec      = w_first ? r_sec : w_gt ? r_max : w_sec_take ? data_in : r_sec;
    assign w_sidx     = w_first ? r_sidx : w_gt ? r_idx : w_sec_take ? r_cnt : r_sidx;
    assign w_margin   = {w_max[DATA_WIDTH-1], w_max} - {w_sec[DATA_WIDTH-1], w_sec};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sec      <= '0;
            r_sidx     <= '0;
            r_sidx_out <= '0;
            r_margin   <= '0;
        end else begin
            if (w_take) begin
                r_sec  <= w_sec;
                r_sidx <= w_sidx;
            end
            if (w_last) begin
                r_sidx_out <= w_sidx;
                r_margin   <= w_margin;
            end
        end
    end

    assign second_idx = r_sidx_out;
    assign margin     = r_margin;
`endif

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_RESET;
        else     r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = (r_state == S_DISCARD && valid_in && r_disc == DCW'(1)) ? S_SCAN : r_state;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_disc  <= DISC_INIT;
            r_cnt   <= '0;
            r_max   <= '0;
            r_idx   <= '0;
            r_valid <= 1'b0;
            r_dec   <= '0;
            r_score <= '0;
        end else begin
            r_valid <= w_last;
            if (valid_in && r_state == S_DISCARD) r_disc <= r_disc - 1'b1;
            if (w_take) begin
                r_cnt <= w_last ? '0 : r_cnt + 1'b1;
                r_max <= w_max;
                r_idx <= w_idx;
            end
            if (w_last) begin
                r_dec   <= w_idx;
                r_score <= w_max;
            end
        end
    end

    always_comb begin
        valid_out = r_valid;
        busy      = (r_state == S_SCAN) && (r_cnt != '0);
        decision  = r_dec;
        max_score = r_score;
    end
endmodule

// File: tb/tb_fc_argmax_classifier.sv
// tb_fc_argmax_classifier: randomized frames checked every cycle against a queue-based argmax model.
module tb_fc_argmax_classifier;
    localparam int N  = 10;
    localparam int DW = 18;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          v0 = 1'b0, v1 = 1'b0;
    logic [DW-1:0] d0 = '0, d1 = '0;
    logic [3:0]    dec0, dec1;
    logic [DW-1:0] max0, max1;
    logic          vo0, vo1, busy0, busy1;
`ifdef FC_ARGMAX_MARGIN_EN
    logic [3:0]    sidx0, sidx1;
    logic [DW:0]   mrg0, mrg1;
`endif

    fc_argmax_classifier #(.NUM_CLASSES(N), .DATA_WIDTH(DW), .IDX_WIDTH(4), .LEAD_DISCARD(0)) dut (
        .clk(clk), .rst(rst), .valid_in(v0), .data_in(d0),
        .decision(dec0), .max_score(max0),
`ifdef FC_ARGMAX_MARGIN_EN
        .second_idx(sidx0), .margin(mrg0),
`endif
        .valid_out(vo0), .busy(busy0)
    );

    fc_argmax_classifier #(.NUM_CLASSES(N), .DATA_WIDTH(DW), .IDX_WIDTH(4), .LEAD_DISCARD(1)) dut_disc (
        .clk(clk), .rst(rst), .valid_in(v1), .data_in(d1),
        .decision(dec1), .max_score(max1),
`ifdef FC_ARGMAX_MARGIN_EN
        .second_idx(sidx1), .margin(mrg1),
`endif
        .valid_out(vo1), .busy(busy1)
    );

    always #5 clk = ~clk;

    int            errors = 0;
    int            checks = 0;
    logic          sel = 1'b0;
    int            q[$];
    int            disc = 0;
    int            fr[N];
    logic [3:0]    exp_dec = '0;
    logic [DW-1:0] exp_max = '0;
    logic          exp_vo = 1'b0;
`ifdef FC_ARGMAX_MARGIN_EN
    logic [3:0]    exp_sidx = '0;
    logic [DW:0]   exp_mrg = '0;
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: winner is the lowest index holding the largest score; runner-up likewise over the rest.
    task automatic judge();
        int best = 0;
        for (int i = 1; i < N; i++) if (q[i] > q[best]) best = i;
        exp_dec = 4'(best);
        exp_max = DW'(q[best]);
`ifdef FC_ARGMAX_MARGIN_EN
        begin
            int s = -1;
            for (int j = 0; j < N; j++) if (j != best && (s < 0 || q[j] > q[s])) s = j;
            exp_sidx = 4'(s);
            exp_mrg  = (DW+1)'(q[best] - q[s]);
        end
`endif
    endtask

    task automatic step(input logic r, input logic v, input int s, input string tag);
        rst = r;
        if (sel) begin v1 = v; d1 = DW'(s); v0 = 1'b0; end
        else     begin v0 = v; d0 = DW'(s); v1 = 1'b0; end
        @(posedge clk);
        @(negedge clk);
        exp_vo = 1'b0;
        if (r) begin
            q.delete();
            disc = sel ? 1 : 0;
            exp_dec = '0;
            exp_max = '0;
`ifdef FC_ARGMAX_MARGIN_EN
            exp_sidx = '0;
            exp_mrg  = '0;
`endif
        end else if (v) begin
            if (disc > 0) disc--;
            else begin
                q.push_back(s);
                if (q.size() == N) begin
                    judge();
                    exp_vo = 1'b1;
                    q.delete();
                end
            end
        end
        check({tag, ".valid_out"}, sel ? vo1 : vo0, exp_vo);
        check({tag, ".busy"}, sel ? busy1 : busy0, q.size() != 0);
        check({tag, ".decision"}, sel ? dec1 : dec0, exp_dec);
        check({tag, ".max_score"}, sel ? max1 : max0, exp_max);
`ifdef FC_ARGMAX_MARGIN_EN
        check({tag, ".second_idx"}, sel ? sidx1 : sidx0, exp_sidx);
        check({tag, ".margin"}, sel ? mrg1 : mrg0, exp_mrg);
`endif
    endtask

    function automatic int rnd(input int lo, input int hi);
        return lo + int'($urandom_range(0, hi - lo));
    endfunction

    task automatic send_frame(input int max_bub, input string tag);
        for (int i = 0; i < N; i++) begin
            step(1'b0, 1'b1, fr[i], tag);
            if (i != N - 1) repeat ($urandom_range(0, max_bub)) step(1'b0, 1'b0, rnd(-131072, 131071), tag);
        end
    endtask

    initial begin
        sel = 1'b1;
        repeat (2) step(1'b1, 1'b0, 0, "reset_disc");
        step(1'b0, 1'b1, 'h1FFFF, "discard");
        for (int i = 0; i < N; i++) fr[i] = rnd(-100, 11);
        fr[3] = 12;
        send_frame(1, "t6_discard");
        repeat (2) step(1'b0, 1'b0, 0, "t6_idle");

        sel = 1'b0;
        repeat (2) step(1'b1, 1'b0, 0, "reset");
        for (int i = 0; i < N; i++) fr[i] = i * 10;
        send_frame(0, "t1_ramp");
        step(1'b0, 1'b0, 0, "t1_idle");
        fr = '{-20, -3, -100, -7, -50, -9, -4, -8, -60, -11};
        send_frame(0, "t2_neg");
        step(1'b0, 1'b0, 0, "t2_idle");
        for (int i = 0; i < N; i++) fr[i] = 0;
        fr[2] = 500;
        fr[7] = 500;
        send_frame(0, "t3_tie");
        step(1'b0, 1'b0, 0, "t3_idle");

        for (int i = 0; i < N; i++) fr[i] = rnd(-200, 200);
        fr[4] = 300;
        fr[8] = 250;
        send_frame(3, "t4_a");
        for (int i = 0; i < N; i++) fr[i] = rnd(-1000, -1);
        fr[0] = 77;
        send_frame(3, "t4_b");
        repeat (3) step(1'b0, 1'b0, 0, "t4_idle");

        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 4000 + i, "t5_partial");
        step(1'b1, 1'b1, 9999, "t5_rst");
        for (int i = 0; i < N; i++) fr[i] = rnd(-4000, 4000);
        fr[6] = 5000;
        send_frame(2, "t5_full");
        step(1'b0, 1'b0, 0, "t5_idle");

        for (int f = 0; f < 20; f++) begin
            for (int i = 0; i < N; i++) fr[i] = ($urandom_range(0, 3) == 0) ? rnd(-4, 4) : rnd(-131072, 131071);
            send_frame(2, "rand");
            repeat ($urandom_range(0, 2)) step(1'b0, 1'b0, 0, "rand_idle");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
